arith_unit_seq: RTL and testbench
=================================

ARITH_UNIT_SEQ -- requirements
Module: arith_unit_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width, in bits, for a and b; legal range 2..32.
REQ-002 clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst  input  1  Reset; asynchronous, active-low (0 = reset).
REQ-004 start  input  1  Request; sampled on rising edges only, and acted on only while idle.
REQ-005 op  input  2  Operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 a  input  WIDTH  First operand (dividend for div), unsigned.
REQ-007 b  input  WIDTH  Second operand (divisor for div), unsigned.
REQ-008 busy  output  1  High whenever the FSM is not in IDLE.
REQ-009 done  output  1  One-cycle pulse; z and err are valid during that cycle.
REQ-010 err  output  1  Divide-by-zero flag for the result presented with done.
REQ-011 z  output  2*WIDTH  Result register.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; no other reachable state.
REQ-013 Accept = rising edge with state IDLE and start=1: a, b and op SHALL be captured, and the iteration counter SHALL be cleared.
REQ-014 start SHALL be ignored in RUN and DONE; the captured operands SHALL be unaffected by a, b or op changes after accept.
REQ-015 On accept with op=00, z SHALL be {1'b0,a}+{1'b0,b} zero-extended to 2*WIDTH, and the next state SHALL be DONE.
REQ-016 On accept with op=01, z SHALL be {1'b0,a}-{1'b0,b} (WIDTH+1-bit two's complement) sign-extended from bit WIDTH, and the next state SHALL be DONE.
REQ-017 On accept with op=11 and b=0, z SHALL be {a, all-ones WIDTH}, err SHALL be 1, the next state SHALL be DONE, and no iterations SHALL run.
REQ-018 On accept with op=10, or op=11 with b!=0, the next state SHALL be RUN with accumulator A=0, Q=a, M=b.
REQ-019 mul SHALL use unsigned shift-add, one step per edge in RUN: if Q[0], add M to A (WIDTH+1-bit carry kept); then shift {carry,A,Q} right by 1.
REQ-020 div SHALL use unsigned restoring division, one step per edge in RUN: shift {A,Q} left by 1; A=A-M; if negative, restore A and set Q[0]=0, else Q[0]=1.
REQ-021 RUN SHALL perform exactly WIDTH steps, counted by a ceil(log2(WIDTH+1))-bit counter; the edge performing step WIDTH SHALL move the FSM to DONE.
REQ-022 Results: mul z={A,Q}=a*b (exact, 2*WIDTH bits); div z={remainder,quotient}={A,Q}; err=0 for both.
REQ-023 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE; done SHALL be 0 in every other state.
REQ-024 Latency from the accept edge to the cycle with done=1 SHALL be 1 cycle for add, sub and div-by-zero, and WIDTH+1 cycles for mul and div.
REQ-025 z and err SHALL hold their last result through IDLE until the next accept; z SHALL be undefined-free (never X) after reset.
REQ-026 A new start SHALL be accepted on the first IDLE edge after DONE; back-to-back throughput = latency+1 cycles.

Reset
REQ-027 rst=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, err=0, z=0, and the counter and A/Q/M to 0.
REQ-028 Reset asserted mid-RUN SHALL abandon the operation with no done pulse, either during or after reset.
REQ-029 After rst returns to 1, the first rising edge SHALL be able to accept start.

Verification (WIDTH=8)
REQ-030 add a=200, b=100 -> done 1 cycle after accept, z=0x012C, err=0.
REQ-031 sub a=5, b=7 -> z=0xFFFE, done after 1 cycle; sub a=7, b=5 -> z=0x0002.
REQ-032 mul a=255, b=255 -> busy for 9 cycles, done on cycle 9, z=0xFE01; mul a=0, b=77 -> z=0x0000.
REQ-033 div a=200, b=7 -> z=0x041C (rem 4, quot 28), err=0; div a=0x55, b=0 -> z=0x55FF, err=1, done after 1 cycle.
REQ-034 Assert start every cycle with operands changing during mul 13*11 -> only the first request is accepted, z=0x008F; the next accept occurs on the first IDLE edge after DONE.
REQ-035 Drop rst to 0 mid-edge-gap in RUN after 4 div steps -> busy=0, z=0, done never pulses; a fresh add 1+1 after release -> z=0x0002.

Source files
------------

// File: rtl/arith_unit_seq.sv
// Sequential add/sub/mul/div unit: add, sub and divide-by-zero finish in one
// cycle; mul (shift-add) and div (restoring) take one step per clock.
module arith_unit_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [2*WIDTH-1:0] z
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_r, q_r, m_r;
   logic             is_div;

   logic             last_step;
   logic [WIDTH:0]   add_sum, sub_diff, mul_sum, div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] acc_step, q_step;

   assign last_step = (state == RUN) && (cnt == LAST_STEP);

   // Single-cycle results, computed straight from the inputs at accept time.
   assign add_sum  = {1'b0, a} + {1'b0, b};
   assign sub_diff = {1'b0, a} - {1'b0, b};

   // One iteration of either algorithm; the carry of the multiply add lands in
   // the accumulator MSB after the right shift.
   assign mul_sum = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : '0);
   assign div_sh  = {acc_r, q_r[WIDTH-1]};
   assign div_ge  = (div_sh >= {1'b0, m_r});

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      acc_step = '0;
      q_step   = '0;
      if (is_div) begin
         acc_step = WIDTH'(div_ge ? div_sh - {1'b0, m_r} : div_sh);
         q_step   = {q_r[WIDTH-2:0], div_ge};
      end else begin
         acc_step = mul_sum[WIDTH:1];
         q_step   = {mul_sum[0], q_r[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start)
                  state_next = (op == 2'b10 || (op == 2'b11 && b != '0)) ? RUN : DONE;
         RUN:  if (last_step) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath registers are cleared by reset so z is never X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         acc_r  <= '0;
         q_r    <= '0;
         m_r    <= '0;
         is_div <= 1'b0;
         err    <= 1'b0;
         z      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt    <= '0;
               acc_r  <= '0;
               q_r    <= a;
               m_r    <= b;
               is_div <= op[0];
               err    <= (op == 2'b11) && (b == '0);
               case (op)
                  2'b00: z <= {{(WIDTH-1){1'b0}}, add_sum};
                  2'b01: z <= {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
                  2'b11: if (b == '0) z <= {a, {WIDTH{1'b1}}};
                  default: ;
               endcase
            end
            RUN: begin
               acc_r <= acc_step;
               q_r   <= q_step;
               cnt   <= cnt + CW'(1);
               if (last_step) z <= {acc_step, q_step};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed bench for arith_unit_seq at WIDTH=8: each step drives one operation
// and checks result, flags and latency against hand-computed values.
module tb_arith_unit_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy, done, err;
   logic [15:0] z;

   int vectors = 0;
   int miscompares = 0;
   int lat;

   arith_unit_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .err(err), .z(z)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, then wait (bounded) for done; lat counts the
   // cycles from the accept edge to the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int l);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      l = 1;
      while (done !== 1'b1 && l < 40) begin
         tick();
         l++;
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err",  err,  0);
      check("rst_z",    z,    0);
      tick();
      rst = 1'b1;

      run_op(2'b00, 8'd200, 8'd100, lat);
      check("add_lat", lat, 1);
      check("add_z",   z,   16'h012C);
      check("add_err", err, 0);
      tick();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_hold_z", z, 16'h012C);

      run_op(2'b01, 8'd5, 8'd7, lat);
      check("sub_neg_lat", lat, 1);
      check("sub_neg_z",   z,   16'hFFFE);
      tick();
      run_op(2'b01, 8'd7, 8'd5, lat);
      check("sub_pos_z", z, 16'h0002);
      tick();

      op = 2'b10; a = 8'd255; b = 8'd255; start = 1'b1;
      tick();
      start = 1'b0;
      check("mul_busy_run", busy, 1);
      check("mul_done_run", done, 0);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("mul_max_lat",  lat,  9);
      check("mul_max_z",    z,    16'hFE01);
      check("mul_max_err",  err,  0);
      check("mul_max_busy", busy, 1);
      tick();
      run_op(2'b10, 8'd0, 8'd77, lat);
      check("mul_zero_z", z, 16'h0000);
      tick();

      run_op(2'b11, 8'd200, 8'd7, lat);
      check("div_lat", lat, 9);
      check("div_z",   z,   16'h041C);
      check("div_err", err, 0);
      tick();
      run_op(2'b11, 8'h55, 8'd0, lat);
      check("div0_lat", lat, 1);
      check("div0_z",   z,   16'h55FF);
      check("div0_err", err, 1);
      tick();
      check("div0_err_hold", err, 1);

      // start held high with operands scrambled every cycle during mul 13*11
      op = 2'b10; a = 8'd13; b = 8'd11; start = 1'b1;
      tick();
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         op = 2'(lat); a = 8'(lat * 37); b = 8'(lat * 5 + 1);
         tick();
         lat++;
      end
      check("hold_lat", lat, 9);
      check("hold_z",   z,   16'h008F);
      op = 2'b00; a = 8'd1; b = 8'd2;
      tick();
      check("hold_idle_busy", busy, 0);
      check("hold_idle_done", done, 0);
      tick();
      start = 1'b0;
      check("hold_next_done", done, 1);
      check("hold_next_z",    z,    16'h0003);
      tick();

      // reset between edges after four div steps
      op = 2'b11; a = 8'd200; b = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("mid_busy_pre", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_z",    z,    0);
      check("mid_rst_done", done, 0);
      tick();
      check("mid_rst_done_e1", done, 0);
      tick();
      check("mid_rst_done_e2", done, 0);
      rst = 1'b1;
      run_op(2'b00, 8'd1, 8'd1, lat);
      check("post_rst_lat", lat, 1);
      check("post_rst_z",   z,   16'h0002);
      tick();
      check("post_rst_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
